digit_to_target: RTL and testbench

- Encoder counterpart to the network's output decoder: converts a digit label (0-9) into the 10-entry Q4.12 target vector the network output is compared against during training/checking.
- Accepts a label over a valid/ready handshake.
- Streams the 10 target values one per accepted beat to the error/backprop stage.
- Also holds a parallel copy of the full vector for the comparator.

---
 rtl/digit_to_target_if.sv | 23 ++
 rtl/digit_to_target.sv | 146 ++++++++++++++
 tb/tb_digit_to_target.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_to_target_if.sv
// Label and target-beat handshake bundle for digit_to_target.
// The slave modport is the encoder's view; master is the label source / target sink.
interface digit_to_target_if;
  logic [3:0]  label_in;
  logic        label_valid;
  logic        label_ready;
  logic        label_err;
  logic [15:0] tgt_data;
  logic [3:0]  tgt_index;
  logic        tgt_valid;
  logic        tgt_ready;
  logic        tgt_last;

  modport master (
    output label_in, label_valid, tgt_ready,
    input  label_ready, label_err, tgt_data, tgt_index, tgt_valid, tgt_last
  );

  modport slave (
    input  label_in, label_valid, tgt_ready,
    output label_ready, label_err, tgt_data, tgt_index, tgt_valid, tgt_last
  );
endinterface

// File: rtl/digit_to_target.sv
// Digit label (0-9) to one-hot Q4.12 target encoder: streams 10 target beats
// over a valid/ready channel and keeps a parallel copy of the finished vector.
module digit_to_target #(
  parameter logic [15:0] HIGH_VAL  = 16'h1000,
  parameter logic [15:0] LOW_VAL   = 16'h0000,
  parameter int          NUM_CLASS = 10
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            clear,
  digit_to_target_if.slave                bus,
  output logic [NUM_CLASS-1:0][15:0]      target_vec,
  output logic                            vec_valid,
  output logic [15:0]                     label_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASS - 1);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                       state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic [3:0]                   label_q, label_d;
  logic                         label_ready_q, label_ready_d;
  logic                         label_err_q, label_err_d;
  logic                         tgt_valid_q, tgt_valid_d;
  logic [15:0]                  tgt_data_q, tgt_data_d;
  logic                         tgt_last_q, tgt_last_d;
  logic [NUM_CLASS-1:0][15:0]   target_vec_q, target_vec_d;
  logic                         vec_valid_q, vec_valid_d;
  logic [15:0]                  label_cnt_q, label_cnt_d;
  logic [3:0]                   next_idx;

  always_comb begin
    // NOTE: every _d is given its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    label_d       = label_q;
    label_ready_d = label_ready_q;
    label_err_d   = 1'b0;
    tgt_valid_d   = tgt_valid_q;
    tgt_data_d    = tgt_data_q;
    tgt_last_d    = tgt_last_q;
    target_vec_d  = target_vec_q;
    vec_valid_d   = 1'b0;
    label_cnt_d   = label_cnt_q;
    next_idx      = idx_q + 4'd1;

    if (clear) begin
      // Abort wins over any handshake this cycle; partial target_vec is kept.
      state_d       = IDLE;
      idx_d         = 4'd0;
      label_ready_d = 1'b1;
      tgt_valid_d   = 1'b0;
      tgt_last_d    = 1'b0;
      tgt_data_d    = LOW_VAL;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.label_valid && label_ready_q) begin
            if (bus.label_in <= LAST_IDX) begin
              state_d       = EMIT;
              label_d       = bus.label_in;
              idx_d         = 4'd0;
              label_ready_d = 1'b0;
              tgt_valid_d   = 1'b1;
              tgt_last_d    = 1'b0;
              tgt_data_d    = (bus.label_in == 4'd0) ? HIGH_VAL : LOW_VAL;
            end else begin
              label_err_d = 1'b1;
            end
          end
        end
        EMIT: begin
          if (tgt_valid_q && bus.tgt_ready) begin
            target_vec_d[idx_q] = tgt_data_q;
            if (idx_q == LAST_IDX) begin
              state_d       = IDLE;
              idx_d         = 4'd0;
              label_ready_d = 1'b1;
              tgt_valid_d   = 1'b0;
              tgt_last_d    = 1'b0;
              tgt_data_d    = LOW_VAL;
              vec_valid_d   = 1'b1;
              label_cnt_d   = label_cnt_q + 16'd1;
            end else begin
              // Precompute the next beat so the outputs stay registered.
              idx_d      = next_idx;
              tgt_data_d = (next_idx == label_q) ? HIGH_VAL : LOW_VAL;
              tgt_last_d = (next_idx == LAST_IDX);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: target_vec is plain flops, not a RAM, so it is reset like any
      // other state to give the comparator a defined all-LOW vector.
      state_q       <= IDLE;
      idx_q         <= 4'd0;
      label_q       <= 4'd0;
      label_ready_q <= 1'b1;
      label_err_q   <= 1'b0;
      tgt_valid_q   <= 1'b0;
      tgt_data_q    <= LOW_VAL;
      tgt_last_q    <= 1'b0;
      target_vec_q  <= {NUM_CLASS{LOW_VAL}};
      vec_valid_q   <= 1'b0;
      label_cnt_q   <= 16'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q       <= state_d;
      idx_q         <= idx_d;
      label_q       <= label_d;
      label_ready_q <= label_ready_d;
      label_err_q   <= label_err_d;
      tgt_valid_q   <= tgt_valid_d;
      tgt_data_q    <= tgt_data_d;
      tgt_last_q    <= tgt_last_d;
      target_vec_q  <= target_vec_d;
      vec_valid_q   <= vec_valid_d;
      label_cnt_q   <= label_cnt_d;
    end
  end

  assign bus.label_ready = label_ready_q;
  assign bus.label_err   = label_err_q;
  assign bus.tgt_valid   = tgt_valid_q;
  assign bus.tgt_data    = tgt_data_q;
  assign bus.tgt_index   = idx_q;
  assign bus.tgt_last    = tgt_last_q;
  assign target_vec      = target_vec_q;
  assign vec_valid       = vec_valid_q;
  assign label_cnt       = label_cnt_q;

  idx_in_range_a : assert property (@(posedge clk) disable iff (!n_rst)
    idx_q <= LAST_IDX);
  valid_only_in_emit_a : assert property (@(posedge clk) disable iff (!n_rst)
    tgt_valid_q |-> (state_q == EMIT));

endmodule

// File: tb/tb_digit_to_target.sv
// Self-checking bench for digit_to_target: table of labels plus hand-written
// clear, back-to-back, async reset and counter-wrap sequences.
module tb_digit_to_target;
  localparam logic [15:0] HIGH = 16'h1000;
  localparam logic [15:0] LOW  = 16'h0000;

  logic             clk   = 1'b0;
  logic             n_rst = 1'b0;
  logic             clear = 1'b0;
  logic [9:0][15:0] target_vec;
  logic             vec_valid;
  logic [15:0]      label_cnt;

  digit_to_target_if bus ();

  digit_to_target dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .bus        (bus),
    .target_vec (target_vec),
    .vec_valid  (vec_valid),
    .label_cnt  (label_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  index;
    logic        last;
  } beat_t;

  // mode: 0 = tgt_ready always high, 1 = 1,0,0 repeating, 2 = random
  typedef struct {
    logic [3:0] label;
    int         mode;
    bit         exp_err;
  } rec_t;

  beat_t            sb_q[$];
  rec_t             tbl[6];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [15:0]      exp_cnt  = 16'd0;
  logic [9:0][15:0] exp_vec;
  int               cyc_n;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit ready_for(input int mode, input int cyc);
    if (mode == 1) return ((cyc - 1) % 3) == 0;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic push_beats(input logic [3:0] lbl);
    for (int k = 0; k < 10; k++) begin
      beat_t b;
      b.data  = (k == int'(lbl)) ? HIGH : LOW;
      b.index = 4'(k);
      b.last  = (k == 9);
      sb_q.push_back(b);
    end
  endtask

  task automatic check_front(input string tag);
    check({tag, "_data"},  bus.tgt_data,  sb_q[0].data);
    check({tag, "_index"}, bus.tgt_index, sb_q[0].index);
    check({tag, "_last"},  bus.tgt_last,  sb_q[0].last);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_label_ready"}, bus.label_ready, 1);
    check({tag, "_tgt_valid"},   bus.tgt_valid,   0);
    check({tag, "_tgt_last"},    bus.tgt_last,    0);
    check({tag, "_tgt_data"},    bus.tgt_data,    LOW);
    check({tag, "_tgt_index"},   bus.tgt_index,   0);
    check({tag, "_label_err"},   bus.label_err,   0);
    check({tag, "_vec_valid"},   vec_valid,       0);
    check({tag, "_label_cnt"},   label_cnt,       0);
    check({tag, "_target_vec"},  target_vec,      {10{LOW}});
  endtask

  task automatic start_label(input logic [3:0] lbl);
    @(negedge clk);
    bus.label_in    = lbl;
    bus.label_valid = 1'b1;
    bus.tgt_ready   = 1'b1;
    check("accept_ready", bus.label_ready, 1);
  endtask

  // Consumes beats against the scoreboard until vec_valid; returns cycles since accept.
  task automatic drain(input logic [3:0] lbl, input int mode, input bit hold_valid,
                       output int cycles);
    bit done = 1'b0;
    cycles = 0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      if (!hold_valid) bus.label_valid = 1'b0;
      if (vec_valid) begin
        done   = 1'b1;
        cycles = cyc;
      end else if (bus.tgt_valid) begin
        if (sb_q.size() == 0) begin
          check("extra_beat", bus.tgt_valid, 0);
          bus.tgt_ready = 1'b1;
        end else begin
          check_front("beat");
          bus.tgt_ready = ready_for(mode, cyc);
          if (bus.tgt_ready) void'(sb_q.pop_front());
        end
      end
    end
    if (!done) begin
      check("vec_valid_timeout", 0, 1);
    end else begin
      exp_cnt++;
      for (int k = 0; k < 10; k++) exp_vec[k] = (k == int'(lbl)) ? HIGH : LOW;
      check("beats_left",   sb_q.size(), 0);
      check("vec_tgt_valid", bus.tgt_valid, 0);
      check("label_cnt",     label_cnt, exp_cnt);
      check("target_vec",    target_vec, exp_vec);
      check("vec_high_elem", target_vec[lbl], HIGH);
    end
    bus.tgt_ready = 1'b1;
  endtask

  task automatic err_label(input logic [3:0] lbl);
    @(negedge clk);
    bus.label_in    = lbl;
    bus.label_valid = 1'b1;
    check("err_accept_ready", bus.label_ready, 1);
    @(negedge clk);
    bus.label_valid = 1'b0;
    check("err_pulse",       bus.label_err,   1);
    check("err_no_valid",    bus.tgt_valid,   0);
    check("err_ready",       bus.label_ready, 1);
    @(negedge clk);
    check("err_pulse_end",   bus.label_err,   0);
    check("err_no_valid2",   bus.tgt_valid,   0);
    check("err_label_cnt",   label_cnt,       exp_cnt);
    check("err_target_vec",  target_vec,      exp_vec);
  endtask

  // Pops in-order beats with tgt_ready high until the given index is presented.
  task automatic run_to_index(input logic [3:0] stop_idx);
    bit hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      bus.label_valid = 1'b0;
      if (bus.tgt_valid && bus.tgt_index == stop_idx) begin
        hit = 1'b1;
      end else if (bus.tgt_valid && sb_q.size() != 0) begin
        check_front("pre");
        void'(sb_q.pop_front());
      end
    end
    check("reach_index", bus.tgt_index, stop_idx);
  endtask

  initial begin
    bus.label_in    = 4'd0;
    bus.label_valid = 1'b0;
    bus.tgt_ready   = 1'b1;
    exp_vec         = {10{LOW}};

    tbl[0] = '{label: 4'd3,  mode: 0, exp_err: 1'b0};
    tbl[1] = '{label: 4'd7,  mode: 1, exp_err: 1'b0};
    tbl[2] = '{label: 4'hC,  mode: 0, exp_err: 1'b1};
    tbl[3] = '{label: 4'd1,  mode: 2, exp_err: 1'b0};
    tbl[4] = '{label: 4'hF,  mode: 0, exp_err: 1'b1};
    tbl[5] = '{label: 4'd8,  mode: 0, exp_err: 1'b0};

    #12;
    check_reset("por");
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].exp_err) begin
        err_label(tbl[i].label);
      end else begin
        start_label(tbl[i].label);
        push_beats(tbl[i].label);
        drain(tbl[i].label, tbl[i].mode, 1'b0, cyc_n);
        if (tbl[i].mode == 0) check("latency", cyc_n, 11);
        @(negedge clk);
        check("vec_valid_pulse", vec_valid, 0);
      end
    end

    // clear on beat index 4 of label 5
    start_label(4'd5);
    push_beats(4'd5);
    run_to_index(4'd4);
    clear         = 1'b1;
    bus.tgt_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int k = 0; k < 4; k++) exp_vec[k] = LOW;
    check("clr_tgt_valid",  bus.tgt_valid,   0);
    check("clr_vec_valid",  vec_valid,       0);
    check("clr_label_cnt",  label_cnt,       exp_cnt);
    check("clr_ready",      bus.label_ready, 1);
    check("clr_target_vec", target_vec,      exp_vec);
    sb_q.delete();

    // label presented together with clear is dropped
    bus.label_in    = 4'd2;
    bus.label_valid = 1'b1;
    clear           = 1'b1;
    @(negedge clk);
    clear           = 1'b0;
    bus.label_valid = 1'b0;
    check("clr_label_dropped", bus.tgt_valid, 0);

    start_label(4'd0);
    push_beats(4'd0);
    drain(4'd0, 0, 1'b0, cyc_n);
    check("after_clr_elem5", target_vec[5], LOW);
    check("after_clr_elem0", target_vec[0], HIGH);

    // back-to-back 9 then 0 with label_valid held
    start_label(4'd9);
    push_beats(4'd9);
    @(posedge clk);
    #1 bus.label_in = 4'd0;
    drain(4'd9, 0, 1'b1, cyc_n);
    check("b2b_latency1", cyc_n, 11);
    check("b2b_ready",    bus.label_ready, 1);
    push_beats(4'd0);
    drain(4'd0, 0, 1'b0, cyc_n);
    check("b2b_latency2", cyc_n, 11);

    // asynchronous reset during beat 6
    start_label(4'd2);
    push_beats(4'd2);
    run_to_index(4'd6);
    #2 n_rst = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    n_rst = 1'b1;
    sb_q.delete();
    exp_cnt = 16'd0;
    exp_vec = {10{LOW}};

    // counter wrap
    @(negedge clk);
    force dut.label_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.label_cnt_q;
    exp_cnt = 16'hFFFF;
    check("wrap_preload", label_cnt, 16'hFFFF);
    start_label(4'd6);
    push_beats(4'd6);
    drain(4'd6, 0, 1'b0, cyc_n);
    check("wrap_zero", label_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
